// File: rtl/icache_refill_responder_pkg.sv
// Shared definitions for the ICache line-refill responder: default geometry and FSM state encoding.
package icache_refill_responder_pkg;

  localparam int DEF_WORD          = 32;
  localparam int DEF_LINE_WIDTH    = 128;
  localparam int DEF_MEM_DEPTH_LOG = 12;
  localparam int DEF_MEM_LATENCY   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } refill_state_t;

endpackage

// File: rtl/icache_refill_responder_if.sv
// Bundle between ICache, refill responder and the synchronous instruction RAM.
// Request is a level: req_valid stays high until the one-cycle resp_ready pulse, which
// qualifies resp_line; abort withdraws an in-flight request and no pulse follows for it.
interface icache_refill_responder_if #(
  parameter int WORD          = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int MEM_DEPTH_LOG = 12
);
  logic                     req_valid;
  logic [WORD-1:0]          req_addr;
  logic                     abort;
  logic                     resp_ready;
  logic [LINE_WIDTH-1:0]    resp_line;
  logic                     busy;
  logic                     mem_en;
  logic [MEM_DEPTH_LOG-1:0] mem_addr;
  logic [WORD-1:0]          mem_rdata;

  modport slave (
    input  req_valid, req_addr, abort, mem_rdata,
    output resp_ready, resp_line, busy, mem_en, mem_addr
  );

  modport master (
    output req_valid, req_addr, abort, mem_rdata,
    input  resp_ready, resp_line, busy, mem_en, mem_addr
  );
endinterface

// File: rtl/icache_refill_responder_refill_line_buffer.sv
// Line assembly register: writes one word slot by index, clears as a whole, presents the line in parallel.
module refill_line_buffer #(
  parameter int WORD  = 32,
  parameter int WORDS = 4,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD-1:0]       wr_data,
  output logic [WORD*WORDS-1:0] line
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line <= '0;
    end else if (clear) begin
      line <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < WORDS; k++) begin
        if (wr_idx == IDX_W'(k)) line[k*WORD +: WORD] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side ICache refill responder: reads one line word-by-word from the instruction RAM,
// assembles it and returns it with a single-cycle resp_ready pulse.
module icache_refill_responder
  import icache_refill_responder_pkg::*;
#(
  parameter int WORD          = DEF_WORD,
  parameter int LINE_WIDTH    = DEF_LINE_WIDTH,
  parameter int MEM_DEPTH_LOG = DEF_MEM_DEPTH_LOG,
  parameter int MEM_LATENCY   = DEF_MEM_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  icache_refill_responder_if.slave  bus,
  output refill_state_t             state
);

  localparam int WPL    = LINE_WIDTH / WORD;
  localparam int CNT_W  = $clog2(WPL);
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int BASE_W = WORD - OFF_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WPL - 1);

  refill_state_t            state_q, next_state;
  logic [BASE_W-1:0]        base_q, addr_base;
  logic [CNT_W-1:0]         issue_cnt, next_issue_cnt, capture_cnt, addr_cnt;
  logic [BASE_W+CNT_W-1:0]  full_addr;
  logic [MEM_LATENCY-1:0]   tag_q;
  logic                     mem_en_q, next_mem_en, resp_ready_q, next_resp_ready, busy_q;
  logic [MEM_DEPTH_LOG-1:0] mem_addr_q, next_mem_addr;
  logic                     accept, cancel, capture_fire, capture_en, last_capture;
  logic [LINE_WIDTH-1:0]    line_q;
  logic                     unused_offset;

  assign accept       = (state_q == IDLE) && bus.req_valid && !bus.abort;
  assign cancel       = bus.abort && ((state_q == ISSUE) || (state_q == DRAIN));
  assign capture_fire = tag_q[MEM_LATENCY-1];
  assign capture_en   = capture_fire && !cancel;
  assign last_capture = capture_fire && (capture_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= next_state;
  end

  // Outputs are computed one cycle ahead here so every port leaves a flop.
  always_comb begin
    next_state      = state_q;
    next_issue_cnt  = issue_cnt;
    next_mem_en     = 1'b0;
    next_resp_ready = 1'b0;
    addr_base       = base_q;
    addr_cnt        = issue_cnt + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          next_state     = ISSUE;
          next_issue_cnt = '0;
          next_mem_en    = 1'b1;
          addr_base      = bus.req_addr[WORD-1:OFF_W];
          addr_cnt       = '0;
        end
      end
      ISSUE: begin
        if (cancel) begin
          next_state = IDLE;
        end else if (issue_cnt == LAST_IDX) begin
          next_state = DRAIN;
        end else begin
          next_issue_cnt = issue_cnt + 1'b1;
          next_mem_en    = 1'b1;
        end
      end
      DRAIN: begin
        if (cancel) begin
          next_state = IDLE;
        end else if (last_capture) begin
          next_state      = RESP;
          next_resp_ready = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    full_addr     = {addr_base, addr_cnt};
    next_mem_addr = next_mem_en ? full_addr[MEM_DEPTH_LOG-1:0] : mem_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q       <= '0;
      issue_cnt    <= '0;
      capture_cnt  <= '0;
      tag_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      issue_cnt    <= next_issue_cnt;
      mem_en_q     <= next_mem_en;
      mem_addr_q   <= next_mem_addr;
      resp_ready_q <= next_resp_ready;
      busy_q       <= (next_state != IDLE);
      if (accept) begin
        base_q      <= bus.req_addr[WORD-1:OFF_W];
        capture_cnt <= '0;
      end else if (capture_en) begin
        capture_cnt <= capture_cnt + 1'b1;
      end
      // Tags follow each issued read through the RAM latency; a cancel drops reads still in flight.
      if (cancel) begin
        tag_q <= '0;
      end else begin
        for (int i = MEM_LATENCY - 1; i > 0; i--) tag_q[i] <= tag_q[i-1];
        tag_q[0] <= mem_en_q;
      end
    end
  end

  refill_line_buffer #(
    .WORD  (WORD),
    .WORDS (WPL),
    .IDX_W (CNT_W)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .clear   (cancel),
    .wr_en   (capture_en),
    .wr_idx  (capture_cnt),
    .wr_data (bus.mem_rdata),
    .line    (line_q)
  );

  assign bus.resp_ready = resp_ready_q;
  assign bus.resp_line  = line_q;
  assign bus.busy       = busy_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign state          = state_q;
  assign unused_offset  = ^bus.req_addr[OFF_W-1:0];

endmodule

// File: tb/tb_icache_refill_responder.sv
// Bench for the refill responder: a default DUT (latency 1, 12-bit RAM) and a latency-2 DUT with a
// 4-bit RAM share one stimulus stream and are both checked every cycle against a line-level model.
module tb_icache_refill_responder;
  import icache_refill_responder_pkg::*;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, abort;
  logic [31:0] req_addr;
  logic [31:0] rb1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  refill_state_t state_a, state_b;

  icache_refill_responder_if #(.WORD(32), .LINE_WIDTH(128), .MEM_DEPTH_LOG(12)) ifa ();
  icache_refill_responder_if #(.WORD(32), .LINE_WIDTH(128), .MEM_DEPTH_LOG(4))  ifb ();

  icache_refill_responder #(.MEM_DEPTH_LOG(12), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst_n), .bus(ifa.slave), .state(state_a));
  icache_refill_responder #(.MEM_DEPTH_LOG(4), .MEM_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst_n), .bus(ifb.slave), .state(state_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ifa.req_valid = req_valid;
  assign ifa.req_addr  = req_addr;
  assign ifa.abort     = abort;
  assign ifb.req_valid = req_valid;
  assign ifb.req_addr  = req_addr;
  assign ifb.abort     = abort;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return a * 32'h1111_1111;
  endfunction

  // RAM models: random junk on cycles with no read in flight.
  always @(posedge clk) begin
    ifa.mem_rdata <= ifa.mem_en ? ram_word({20'd0, ifa.mem_addr}) : $urandom();
    rb1           <= ifb.mem_en ? ram_word({28'd0, ifb.mem_addr}) : $urandom();
    ifb.mem_rdata <= rb1;
  end

  logic         o_busy [2];
  logic         o_en   [2];
  logic         o_rdy  [2];
  logic [11:0]  o_addr [2];
  logic [127:0] o_line [2];
  assign o_busy[0] = ifa.busy;       assign o_busy[1] = ifb.busy;
  assign o_en[0]   = ifa.mem_en;     assign o_en[1]   = ifb.mem_en;
  assign o_rdy[0]  = ifa.resp_ready; assign o_rdy[1]  = ifb.resp_ready;
  assign o_addr[0] = ifa.mem_addr;   assign o_addr[1] = {8'd0, ifb.mem_addr};
  assign o_line[0] = ifa.resp_line;  assign o_line[1] = ifb.resp_line;

  // Model: per DUT, whether a refill is live and k = cycles since its accept edge (1 = first read).
  int           lat  [2] = '{1, 2};
  int           dlog [2] = '{12, 4};
  bit           act  [2] = '{0, 0};
  int           k    [2] = '{0, 0};
  logic [31:0]  lbase[2];
  logic [127:0] exp_line[2];

  function automatic logic [31:0] word_addr(input int d, input int j);
    logic [31:0] mask;
    mask = (32'd1 << dlog[d]) - 32'd1;
    return ((lbase[d] << 2) + 32'(j)) & mask;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        act[d] = 1'b0;
        k[d]   = 0;
      end else if (act[d]) begin
        if ((abort && k[d] <= W + lat[d]) || k[d] == W + lat[d] + 1) act[d] = 1'b0;
        else k[d] = k[d] + 1;
      end else if (req_valid && !abort) begin
        act[d]   = 1'b1;
        k[d]     = 1;
        lbase[d] = req_addr >> 4;
        for (int j = 0; j < W; j++) exp_line[d][32*j +: 32] = ram_word(word_addr(d, j));
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
  endtask

  logic        e_en, e_rdy;
  logic [11:0] e_addr;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      e_en   = act[d] && (k[d] <= W);
      e_rdy  = act[d] && (k[d] == W + lat[d] + 1);
      e_addr = word_addr(d, k[d] - 1);
      check($sformatf("busy_%0d", d), o_busy[d], act[d]);
      check($sformatf("mem_en_%0d", d), o_en[d], e_en);
      check($sformatf("resp_ready_%0d", d), o_rdy[d], e_rdy);
      if (e_en)  check($sformatf("mem_addr_%0d", d), o_addr[d], e_addr);
      if (e_rdy) check($sformatf("resp_line_%0d", d), o_line[d], exp_line[d]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];

  // One request held for a single cycle; records both DUTs' pulse offsets/lines and one DUT's read addresses.
  task automatic refill(input logic [31:0] addr, input int sel, output int ra, output int rb,
                        output logic [127:0] la, output logic [127:0] lb, output int busy_b);
    int t0;
    ra = -1; rb = -1; la = '0; lb = '0; busy_b = 0;
    got_q.delete();
    req_valid = 1'b1; req_addr = addr;
    step();
    t0 = cyc;
    req_valid = 1'b0; req_addr = $urandom();
    for (int i = 0; i < 20; i++) begin
      if (o_en[sel]) got_q.push_back(o_addr[sel]);
      if (o_busy[1]) busy_b++;
      if (o_rdy[0] && ra < 0) begin ra = cyc - t0 + 1; la = o_line[0]; end
      if (o_rdy[1] && rb < 0) begin rb = cyc - t0 + 1; lb = o_line[1]; end
      step();
    end
  endtask

  task automatic cmp_addrs(input string name);
    check({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(name, got_q[i], exp_q[i]);
  endtask

  int           ra, rb, busy_b, t0, p1, p2, pulses;
  logic [127:0] la, lb, l2;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; abort = 1'b0;
    #1;
    check("rst_busy_a", ifa.busy, 1'b0);
    check("rst_mem_en_a", ifa.mem_en, 1'b0);
    check("rst_mem_addr_a", ifa.mem_addr, 12'd0);
    check("rst_resp_ready_b", ifb.resp_ready, 1'b0);
    check("rst_resp_line_a", ifa.resp_line, 128'd0);
    check("rst_state_b", state_b, IDLE);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset while the third read is on the bus.
    req_valid = 1'b1; req_addr = 32'h14;
    step();
    t0 = cyc; req_valid = 1'b0;
    step(); step();
    check("t1_addr_before_reset", ifa.mem_addr, 12'd6);
    rst_n = 1'b0;
    #1;
    check("t1_busy_a", ifa.busy, 1'b0);
    check("t1_mem_en_a", ifa.mem_en, 1'b0);
    check("t1_mem_addr_a", ifa.mem_addr, 12'd0);
    check("t1_mem_en_b", ifb.mem_en, 1'b0);
    check("t1_resp_line_a", ifa.resp_line, 128'd0);
    check("t1_state_a", state_a, IDLE);
    step(); step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      if (o_rdy[0] || o_rdy[1]) pulses++;
      step();
    end
    check("t1_no_pulse", pulses, 0);

    // Basic refill; the second DUT has latency 2.
    refill(32'h14, 0, ra, rb, la, lb, busy_b);
    exp_q = '{12'd4, 12'd5, 12'd6, 12'd7};
    cmp_addrs("t2_addr_seq");
    check("t2_ready_cycle_a", ra, 6);
    check("t2_line_a", la, 128'h77777777_66666666_55555555_44444444);
    check("t6_ready_cycle_b", rb, 7);
    check("t6_line_b", lb, 128'h77777777_66666666_55555555_44444444);
    check("t6_busy_cycles_b", busy_b, 7);

    // Back-to-back: request held through the pulse with a new address.
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    t0 = cyc; p1 = -1; p2 = -1; l2 = '0;
    for (int i = 0; i < 20 && p1 < 0; i++) begin
      if (o_rdy[0]) p1 = cyc;
      else step();
    end
    req_addr = 32'h20;
    check("t3_first_ready", p1 - t0 + 1, 6);
    for (int i = 0; i < 20 && p2 < 0; i++) begin
      step();
      if (o_rdy[0]) begin p2 = cyc; l2 = o_line[0]; end
    end
    req_valid = 1'b0;
    check("t3_gap", p2 - p1, 7);
    check("t3_line", l2, 128'hBBBBBBBB_AAAAAAAA_99999999_88888888);
    repeat (12) step();

    // Abort while the last word is in flight, then a clean refill.
    req_valid = 1'b1; req_addr = 32'h30;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_busy_a", ifa.busy, 1'b0);
    check("t4_state_a", state_a, IDLE);
    check("t4_busy_b", ifb.busy, 1'b0);
    pulses = 0;
    repeat (10) begin
      if (o_rdy[0] || o_rdy[1]) pulses++;
      step();
    end
    check("t4_no_pulse", pulses, 0);
    refill(32'h40, 0, ra, rb, la, lb, busy_b);
    check("t4_ready_cycle_a", ra, 6);
    check("t4_line_a", la, 128'h44444443_33333332_22222221_11111110);

    // Address wrap on the 16-word RAM.
    refill(32'h44, 1, ra, rb, la, lb, busy_b);
    exp_q = '{12'd0, 12'd1, 12'd2, 12'd3};
    cmp_addrs("t5_addr_seq");
    check("t5_line_b", lb, 128'h33333333_22222222_11111111_00000000);
    check("t5_line_a", la, 128'h44444443_33333332_22222221_11111110);

    // Random traffic: level requests, wandering addresses, occasional aborts.
    for (int i = 0; i < 800; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = $urandom();
      abort     = ($urandom_range(0, 15) == 0);
      step();
    end
    req_valid = 1'b0; abort = 1'b0;
    repeat (15) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
